// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// Holds the default DATA_BITS/OVERSAMPLE values, the line levels of a frame
// and the transmitter state type.
// Optional macro UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  // Defaults shared by both directions of the link
  localparam int UART_DATA_BITS_DEF  = 8;
  localparam int UART_OVERSAMPLE_DEF = 4;

  // Line levels of an asynchronous character
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } uart_tx_state_t;
`else
  // Without parity four states fit in two bits
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/shifter_tx.sv
// Transmit data path: load/shift register plus data-bit counter.
// Latency: load and shift take effect on the next rising i_clk edge.
// Backpressure: none; the FSM in uart_tx decides when to load and shift.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_load, i_data capture a new word (clears the bit counter)
//   i_shift        advance to the next data bit (shift right, count up)
//   o_bit0         bit currently on the line (register LSB)
//   o_bit1         bit that will be on the line after the next shift
//   o_last         the bit in o_bit0 is the final data bit
//   o_parity       even parity of the captured word (UART_TX_PARITY_EN only)
module shifter_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_shift,
  output logic                 o_bit0,
  output logic                 o_bit1,
  output logic                 o_last
`ifdef UART_TX_PARITY_EN
  ,
  output logic                 o_parity
`endif
);

  localparam int CNT_W = $clog2(DATA_BITS);

  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (i_load) begin
      shreg_d   = i_data;
      bit_cnt_d = '0;
    end else if (i_shift) begin
      shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken at load time because shifting destroys the word
  logic parity_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      parity_q <= 1'b0;
    end else if (i_load) begin
      parity_q <= ^i_data;
    end
  end

  assign o_parity = parity_q;
`endif

  assign o_bit0 = shreg_q[0];
  assign o_bit1 = shreg_q[1];
  assign o_last = (bit_cnt_q == CNT_W'(DATA_BITS - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data LSB first, optional even parity,
// one stop bit; each bit lasts OVERSAMPLE i_baudclk ticks.
// Latency: o_txd/o_ready fall one i_clk after the accepting edge.
// Backpressure: o_ready low for the whole frame; i_valid is ignored (not
// buffered) while busy, so the source holds i_valid until o_ready.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data).
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_baudclk        one-cycle baud tick enable
//   i_data, i_valid  word to send and its valid
//   o_ready          idle, a word is accepted when i_valid is high
//   o_txd            serial line, idle high
//   o_busy           frame in progress (~o_ready)
//   o_done           one-cycle pulse after the stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baudclk,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_txd,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int TICK_W = $clog2(OVERSAMPLE);

  uart_tx_state_t    state_q;
  logic [TICK_W-1:0] tick_q;
  logic              txd_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic bit_end;
  logic accept;
  logic sh_load;
  logic sh_shift;
  logic sh_bit0;
  logic sh_bit1;
  logic sh_last;
`ifdef UART_TX_PARITY_EN
  logic sh_parity;
`endif

  // A serial bit ends on the baud tick that completes its OVERSAMPLE ticks
  assign bit_end  = i_baudclk && (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign accept   = (state_q == TX_IDLE) && i_valid;
  assign sh_load  = accept;
  assign sh_shift = (state_q == TX_DATA) && bit_end;

  shifter_tx #(
    .DATA_BITS (DATA_BITS)
  ) u_shifter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (sh_load),
    .i_data   (i_data),
    .i_shift  (sh_shift),
    .o_bit0   (sh_bit0),
    .o_bit1   (sh_bit1),
    .o_last   (sh_last)
`ifdef UART_TX_PARITY_EN
    ,
    .o_parity (sh_parity)
`endif
  );

  // The line level is registered, so every transition loads the level of
  // the bit that starts on the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= TX_IDLE;
      tick_q  <= '0;
      txd_q   <= IDLE_LVL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Baud ticks only count inside a frame
      if (state_q != TX_IDLE && i_baudclk) begin
        tick_q <= bit_end ? '0 : tick_q + TICK_W'(1);
      end

      case (state_q)
        TX_IDLE: begin
          if (accept) begin
            state_q <= TX_START;
            tick_q  <= '0;
            txd_q   <= START_LVL;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        TX_START: begin
          if (bit_end) begin
            state_q <= TX_DATA;
            txd_q   <= sh_bit0;
          end
        end

        TX_DATA: begin
          if (bit_end) begin
            if (sh_last) begin
`ifdef UART_TX_PARITY_EN
              state_q <= TX_PARITY;
              txd_q   <= sh_parity;
`else
              state_q <= TX_STOP;
              txd_q   <= STOP_LVL;
`endif
            end else begin
              // The register shifts on this same edge, so bit1 is next
              txd_q <= sh_bit1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_end) begin
            state_q <= TX_STOP;
            txd_q   <= STOP_LVL;
          end
        end
`endif

        TX_STOP: begin
          if (bit_end) begin
            state_q <= TX_IDLE;
            txd_q   <= IDLE_LVL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= TX_IDLE;
          txd_q   <= IDLE_LVL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_txd   = txd_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter: accepts a parallel data word through a valid/ready handshake and shifts it out on a single line as a framed asynchronous character (start bit, data LSB first, optional parity, one stop bit). It sits in the transmit path opposite the receiver and is driven by the same i_clk and i_baudclk enable. Each bit is held for OVERSAMPLE baud ticks, so the receiver's multi-sample majority/unanimity check sees a stable level for the whole bit.

## Interface
- DATA_BITS, 8: data word width, legal range 5..9.
- OVERSAMPLE, 4: i_baudclk ticks per serial bit, legal range 2..16.
- i_clk  input  1  system clock; all state changes on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_baudclk  input  1  baud-tick enable, one i_clk cycle wide; sampled only at posedge i_clk.
- i_data  input  DATA_BITS  word to transmit.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  transmitter idle, can accept a word.
- o_txd  output  1  serial line; idle high.
- o_busy  output  1  frame in progress (equals ~o_ready).
- o_done  output  1  one-cycle pulse when the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY (only with UART_TX_PARITY_EN), STOP.
- IDLE: o_txd=1, o_ready=1. On posedge i_clk with i_valid && o_ready: capture i_data into the shift register, clear the tick and bit counters, go to START.
- START: o_txd=0 for OVERSAMPLE ticks, then DATA.
- DATA: o_txd = shift register bit 0; after OVERSAMPLE ticks shift right by one and increment the bit counter; after DATA_BITS bits go to PARITY or STOP.
- PARITY: o_txd = XOR of the captured word (even parity) for OVERSAMPLE ticks, then STOP.
- STOP: o_txd=1 for OVERSAMPLE ticks, then IDLE with o_done pulsed.
- Tick counter: width clog2(OVERSAMPLE). It increments only on cycles where i_baudclk=1. A bit ends on the i_baudclk cycle where the counter equals OVERSAMPLE-1, and the counter wraps to 0 on that cycle.
- The captured word is immutable during a frame; changes on i_data after acceptance are ignored.
- i_valid while busy is ignored, with no buffering; the source must hold i_valid until it sees o_ready.
- i_baudclk is ignored in IDLE.

## Timing
- Reset values: state IDLE, o_txd=1, o_ready=1, o_busy=0, o_done=0, counters 0, shift register 0.
- Reset asserted mid-frame: on the next posedge the frame is abandoned and all outputs take their reset values. No partial stop bit is sent; the line simply returns high.
- Acceptance to start bit: o_txd falls and o_ready falls in the cycle after the accepting edge (1 i_clk latency).
- Frame length: (1 + DATA_BITS + P + 1) × OVERSAMPLE baud ticks, with P=1 if parity is enabled, else 0.
- o_done and o_ready rise together in the cycle after the final stop-bit tick.
- Back-to-back: if i_valid is high in that cycle, the next frame is accepted immediately, giving exactly one stop bit between frames.
- i_rst and i_valid in the same cycle: reset wins and nothing is accepted.
- i_baudclk high in the accepting cycle does not count toward the start bit.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state exists and an even-parity bit is sent after the data bits.
- UART_TX_PARITY_EN undefined: the PARITY state, the parity logic and its state encoding are compiled out, and DATA goes directly to STOP.

## Structure
- Shared package uart_pkg holds:
  - the state enum type uart_tx_state_t;
  - the frame constants START_LVL=0, STOP_LVL=1, IDLE_LVL=1;
  - the default DATA_BITS/OVERSAMPLE values, shared with the receiver.
- One sub-module, shifter_tx. It holds the load/shift register and the bit counter and reports the last data bit. The FSM and tick counter live in uart_tx.

## Test plan
- Reset, then no i_valid for 100 cycles -> o_txd=1, o_ready=1, o_done never pulses.
- Send 0x55, DATA_BITS=8, OVERSAMPLE=4, i_baudclk every 3rd cycle, parity off -> o_txd sequence is 0,1,0,1,0,1,0,1,0,1, each level exactly 4 ticks; 40 ticks total; o_done pulses once.
- With UART_TX_PARITY_EN, send 0xA7 -> data bits 1,1,1,0,0,1,0,1, then parity bit 1, then stop; frame is 44 ticks.
- Back-to-back 0x00 then 0xFF with i_valid held high -> a single 4-tick stop bit between frames; the second start bit begins the cycle after o_done.
- Change i_data and pulse i_valid mid-frame -> the transmitted word stays the first one and the second request is not accepted until o_ready.
- Assert i_rst during data bit 3 -> the next cycle shows o_txd=1 and o_ready=1; a new 0x3C sent afterwards is framed correctly.
